// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared constants and types for the two-master cache-line burst arbiter.
//   LINE_WORDS / BEAT_W : words per cache line and width of the beat index
//   M_INST / M_DATA     : master identifiers (also the bit index into req/pick)
//   state_t             : arbiter FSM states
package mem_arb_pkg;

   localparam int LINE_WORDS = 4;
   localparam int BEAT_W     = 2;

   localparam logic M_INST = 1'b0;
   localparam logic M_DATA = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Per-master burst port between a cache management unit and mem_arbiter.
//   req/we/addr/din        : master -> arbiter (request, direction, line address, write word)
//   gnt/beat/dout/valid/done : arbiter -> master (ownership, beat index, read word, beat and burst completion)
// Modports: master (cache side), slave (arbiter side).
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic              gnt;
   logic [1:0]        beat;
   logic [DATA_W-1:0] dout;
   logic              valid;
   logic              done;

   modport master (
      output req, we, addr, din,
      input  gnt, beat, dout, valid, done
   );

   modport slave (
      input  req, we, addr, din,
      output gnt, beat, dout, valid, done
   );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2
// Two-request round-robin picker, purely combinational.
//   req[1:0] : request vector, indexed by master ID (M_INST = bit 0, M_DATA = bit 1)
//   last     : master granted most recently
//   pick[1:0]: one-hot choice, all zero when nobody requests
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);

   // On a tie the master that did not own the previous burst wins.
   always_comb begin
      pick = 2'b00;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = (last == M_INST) ? 2'b10 : 2'b01;
         default: pick = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one RAM port between the instruction-side and data-side cache units.
// Each grant moves one 4-word cache line (fill or write-back) as four beats.
//   clk, rst         : clock, asynchronous active-low reset
//   i_bus, d_bus     : instruction / data master ports (mem_arbiter_if.slave)
//   ram_cs, ram_we   : RAM strobe and write enable
//   ram_addr, ram_din: RAM word address and write data
//   ram_dout, ram_ack: RAM read data and per-beat acknowledge
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   mem_arbiter_if.slave      i_bus,
   mem_arbiter_if.slave      d_bus,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic              ram_ack
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   state_t             state;
   logic               owner;
   logic               last_gnt;
   logic               we_lat;
   logic [ADDR_W-5:0]  base;
   logic [BEAT_W-1:0]  beat;
   logic [1:0]         pick;
   logic               busy;
   logic               own_i;
   logic               own_d;

   // Byte offset within the line is meaningless to a line transfer.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_bus.addr[3:0], d_bus.addr[3:0]};

   rr_arb2 u_rr (
      .req  ({d_bus.req, i_bus.req}),
      .last (last_gnt),
      .pick (pick)
   );

   // Line address and direction are captured at grant so the master may
   // change or drop them during the burst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         owner    <= M_INST;
         last_gnt <= M_DATA;
         we_lat   <= 1'b0;
         base     <= '0;
         beat     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick != 2'b00) begin
                  owner    <= pick[M_DATA];
                  last_gnt <= pick[M_DATA];
                  we_lat   <= pick[M_DATA] ? d_bus.we : i_bus.we;
                  base     <= pick[M_DATA] ? d_bus.addr[ADDR_W-1:4] : i_bus.addr[ADDR_W-1:4];
                  beat     <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (ram_ack) begin
                  beat <= beat + 1'b1;
                  if (beat == LAST_BEAT) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy  = (state == BURST);
   assign own_i = busy && (owner == M_INST);
   assign own_d = busy && (owner == M_DATA);

   // Beat index never carries into bit 4, so a burst stays inside its line.
   assign ram_cs   = busy;
   assign ram_we   = busy & we_lat;
   assign ram_addr = busy ? {base, beat, 2'b00} : '0;
   assign ram_din  = own_d ? d_bus.din : (own_i ? i_bus.din : '0);

   assign i_bus.gnt   = own_i;
   assign i_bus.beat  = own_i ? beat : '0;
   assign i_bus.valid = own_i & ram_ack;
   assign i_bus.dout  = (own_i & ram_ack) ? ram_dout : '0;
   assign i_bus.done  = own_i & ram_ack & (beat == LAST_BEAT);

   assign d_bus.gnt   = own_d;
   assign d_bus.beat  = own_d ? beat : '0;
   assign d_bus.valid = own_d & ram_ack;
   assign d_bus.dout  = (own_d & ram_ack) ? ram_dout : '0;
   assign d_bus.done  = own_d & ram_ack & (beat == LAST_BEAT);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. Each requested burst pushes its four
// expected beats into a scoreboard queue; beats are popped and compared as
// the arbiter acknowledges them. RAM read data is a fixed function of the
// address so expected fill data comes from the bench's own RAM model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam logic [31:0] RAM_KEY = 32'h5A5A_C3C3;
   localparam logic [31:0] JUNK    = 32'hBAD0_0000;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        last;
   } beat_exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              ram_cs;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;
   logic              ram_ack;

   beat_exp_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int ncyc;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i_bus ();
   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) d_bus ();

   assign ram_dout = ram_addr ^ RAM_KEY;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_bus    (i_bus),
      .d_bus    (d_bus),
      .ram_cs   (ram_cs),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout),
      .ram_ack  (ram_ack)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Push the four expected beats of one line transfer.
   task automatic pushBurst(input logic [31:0] line_addr, input logic we, input logic [31:0] wbase);
      beat_exp_t e;
      for (int b = 0; b < LINE_WORDS; b++) begin
         e.addr  = {line_addr[31:4], 4'(b * 4)};
         e.we    = we;
         e.wdata = wbase + 32'(b);
         e.rdata = e.addr ^ RAM_KEY;
         e.last  = (b == LINE_WORDS - 1);
         exp_q.push_back(e);
      end
   endtask

   // Called at posedge+1 with the arbiter idle and a request pending:
   // checks the idle cycle, then steps to the granting edge.
   task automatic applyStimulus();
      @(negedge clk);
      checkOutput("idle_ram_cs", 32'(ram_cs), 32'd0);
      checkOutput("idle_i_gnt", 32'(i_bus.gnt), 32'd0);
      checkOutput("idle_d_gnt", 32'(d_bus.gnt), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Runs an owned burst, acking every ack_period-th cycle, until
   // stop_beats beats have completed or the cycle budget expires.
   task automatic runBurst(input logic is_d, input int ack_period, input int stop_beats, output int cycles);
      beat_exp_t e;
      int        popped;
      logic      finished;
      popped   = 0;
      finished = 1'b0;
      cycles   = 0;
      while (!finished && cycles < 64) begin
         ram_ack = ((cycles % ack_period) == ack_period - 1);
         if (exp_q.size() > 0) begin
            if (is_d) begin
               d_bus.din = exp_q[0].wdata;
               i_bus.din = JUNK;
            end else begin
               i_bus.din = exp_q[0].wdata;
               d_bus.din = JUNK;
            end
         end
         @(negedge clk);
         checkOutput("burst_ram_cs", 32'(ram_cs), 32'd1);
         checkOutput("burst_own_gnt", 32'(is_d ? d_bus.gnt : i_bus.gnt), 32'd1);
         checkOutput("burst_other_gnt", 32'(is_d ? i_bus.gnt : d_bus.gnt), 32'd0);
         checkOutput("burst_other_valid", 32'(is_d ? i_bus.valid : d_bus.valid), 32'd0);
         checkOutput("burst_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            checkOutput("burst_ram_addr", ram_addr, exp_q[0].addr);
            checkOutput("burst_ram_we", 32'(ram_we), 32'(exp_q[0].we));
            checkOutput("burst_own_beat", 32'(is_d ? d_bus.beat : i_bus.beat), 32'(exp_q[0].addr[3:2]));
            if (ram_ack) begin
               e = exp_q.pop_front();
               popped++;
               checkOutput("beat_valid", 32'(is_d ? d_bus.valid : i_bus.valid), 32'd1);
               checkOutput("beat_done", 32'(is_d ? d_bus.done : i_bus.done), 32'(e.last));
               if (e.we) begin
                  checkOutput("beat_ram_din", ram_din, e.wdata);
               end else begin
                  checkOutput("beat_dout", is_d ? d_bus.dout : i_bus.dout, e.rdata);
               end
               finished = (popped == stop_beats);
            end else begin
               checkOutput("wait_valid", 32'(is_d ? d_bus.valid : i_bus.valid), 32'd0);
            end
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      ram_ack = 1'b0;
      checkOutput("burst_finished", 32'(finished), 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst         = 1'b0;
      ram_ack     = 1'b1;
      i_bus.req   = 1'b0;
      i_bus.we    = 1'b0;
      i_bus.addr  = '0;
      i_bus.din   = '0;
      d_bus.req   = 1'b0;
      d_bus.we    = 1'b0;
      d_bus.addr  = '0;
      d_bus.din   = '0;

      // Reset state, with a stray ack present.
      #12;
      checkOutput("rst_ram_cs", 32'(ram_cs), 32'd0);
      checkOutput("rst_ram_addr", ram_addr, 32'd0);
      checkOutput("rst_i_valid", 32'(i_bus.valid), 32'd0);
      checkOutput("rst_d_done", 32'(d_bus.done), 32'd0);
      @(posedge clk);
      #1;
      rst     = 1'b1;
      ram_ack = 1'b0;

      // Single fill, zero-wait RAM.
      $display("[TB] single fill");
      i_bus.req  = 1'b1;
      i_bus.we   = 1'b0;
      i_bus.addr = 32'h1234_5678;
      pushBurst(32'h1234_5678, 1'b0, 32'h0);
      applyStimulus();
      runBurst(M_INST, 1, 4, ncyc);
      checkOutput("fill_cycles", 32'(ncyc), 32'd4);
      i_bus.req = 1'b0;

      // Reset again so last_gnt is back to data before the tie test.
      rst = 1'b0;
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Simultaneous requests: instruction, data, instruction.
      $display("[TB] simultaneous requests");
      i_bus.req  = 1'b1;
      i_bus.addr = 32'h0000_4000;
      d_bus.req  = 1'b1;
      d_bus.we   = 1'b0;
      d_bus.addr = 32'h0000_8010;
      pushBurst(32'h0000_4000, 1'b0, 32'h0);
      applyStimulus();
      runBurst(M_INST, 1, 4, ncyc);
      pushBurst(32'h0000_8010, 1'b0, 32'h0);
      applyStimulus();
      runBurst(M_DATA, 1, 4, ncyc);
      pushBurst(32'h0000_4000, 1'b0, 32'h0);
      applyStimulus();
      runBurst(M_INST, 2, 4, ncyc);
      checkOutput("tie_third_cycles", 32'(ncyc), 32'd8);
      i_bus.req = 1'b0;
      d_bus.req = 1'b0;

      // Write-back with ack every third cycle.
      $display("[TB] write-back with waits");
      d_bus.req  = 1'b1;
      d_bus.we   = 1'b1;
      d_bus.addr = 32'h8000_0044;
      pushBurst(32'h8000_0044, 1'b1, 32'hA0);
      applyStimulus();
      runBurst(M_DATA, 3, 4, ncyc);
      checkOutput("wb_cycles", 32'(ncyc), 32'd12);
      d_bus.req = 1'b0;

      // Request dropped and address/direction changed after grant.
      $display("[TB] request dropped after grant");
      d_bus.req  = 1'b1;
      d_bus.we   = 1'b0;
      d_bus.addr = 32'h0000_2000;
      pushBurst(32'h0000_2000, 1'b0, 32'h0);
      applyStimulus();
      d_bus.req  = 1'b0;
      d_bus.we   = 1'b1;
      d_bus.addr = 32'hFFFF_FFF0;
      runBurst(M_DATA, 2, 4, ncyc);
      applyStimulus();

      // Async reset during beat 2, then re-request from beat 0.
      $display("[TB] reset mid-burst");
      i_bus.req  = 1'b1;
      i_bus.we   = 1'b0;
      i_bus.addr = 32'h3000_0000;
      pushBurst(32'h3000_0000, 1'b0, 32'h0);
      applyStimulus();
      runBurst(M_INST, 1, 2, ncyc);
      ram_ack = 1'b1;
      #2;
      checkOutput("pre_rst_addr", ram_addr, 32'h3000_0008);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_ram_cs", 32'(ram_cs), 32'd0);
      checkOutput("mid_rst_i_gnt", 32'(i_bus.gnt), 32'd0);
      checkOutput("mid_rst_i_valid", 32'(i_bus.valid), 32'd0);
      checkOutput("mid_rst_i_done", 32'(i_bus.done), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("held_rst_ram_cs", 32'(ram_cs), 32'd0);
      rst     = 1'b1;
      ram_ack = 1'b0;
      exp_q.delete();
      pushBurst(32'h3000_0000, 1'b0, 32'h0);
      applyStimulus();
      runBurst(M_INST, 1, 4, ncyc);
      i_bus.req = 1'b0;

      // Spurious ack while idle.
      $display("[TB] spurious ack in idle");
      ram_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("spur_ram_cs", 32'(ram_cs), 32'd0);
         checkOutput("spur_i_valid", 32'(i_bus.valid), 32'd0);
         checkOutput("spur_d_valid", 32'(d_bus.valid), 32'd0);
         checkOutput("spur_i_done", 32'(i_bus.done), 32'd0);
         checkOutput("spur_d_done", 32'(d_bus.done), 32'd0);
         @(posedge clk);
         #1;
      end
      ram_ack = 1'b0;

      // Still idle: a fresh request starts a clean burst at beat 0.
      d_bus.req  = 1'b1;
      d_bus.we   = 1'b0;
      d_bus.addr = 32'h0000_0FF8;
      pushBurst(32'h0000_0FF8, 1'b0, 32'h0);
      applyStimulus();
      runBurst(M_DATA, 1, 4, ncyc);
      d_bus.req = 1'b0;
      checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
